// File: rtl/alut_age_sweep14_pkg.sv
// -----------------------------------------------------------------------------
// alut_pkg14: shared definitions for the ALUT aging logic.
//   - ALUT entry field bit positions (valid, port, MAC, timestamp)
//   - default entry/address/time widths and entry count
//   - state encoding of the age-sweep FSM
// -----------------------------------------------------------------------------
package alut_pkg14;

    localparam int DW_DEF = 83;   // entry width
    localparam int AW_DEF = 8;    // entry RAM address width
    localparam int TW_DEF = 32;   // timestamp width
    localparam int DD_DEF = 256;  // entries swept

    // Entry layout: {valid, port[1:0], mac[47:0], timestamp[31:0]}
    localparam int VALID_BIT = 82;
    localparam int PORT_MSB  = 81;
    localparam int PORT_LSB  = 80;
    localparam int MAC_MSB   = 79;
    localparam int MAC_LSB   = 32;
    localparam int TS_MSB    = 31;
    localparam int TS_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WRITE,
        ST_NEXT
    } sweep_state_t;

endpackage

// File: rtl/alut_age_sweep14_if.sv
// -----------------------------------------------------------------------------
// alut_age_sweep14_if: ALUT entry RAM age-checker port plus the snooped
// address-checker write port.
//   master : the age sweeper (drives age-port address/write/data, reads the
//            registered read data and observes the address-checker writes)
//   slave  : the RAM / address-checker side
// -----------------------------------------------------------------------------
interface alut_age_sweep14_if
    import alut_pkg14::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic [AW-1:0] mem_addr_age14;        // age-port address
    logic          mem_write_age14;       // age-port write strobe (1 = write)
    logic [DW-1:0] mem_write_data_age14;  // age-port write data
    logic [DW-1:0] mem_read_data_age14;   // age-port read data, one cycle late
    logic [AW-1:0] mem_addr_add14;        // address-checker port address
    logic          mem_write_add14;       // address-checker port write strobe

    modport master (
        output mem_addr_age14, mem_write_age14, mem_write_data_age14,
        input  mem_read_data_age14, mem_addr_add14, mem_write_add14
    );

    modport slave (
        input  mem_addr_age14, mem_write_age14, mem_write_data_age14,
        output mem_read_data_age14, mem_addr_add14, mem_write_add14
    );
endinterface

// File: rtl/alut_age_sweep14_cmp.sv
// -----------------------------------------------------------------------------
// alut_age_cmp14: combinational expiry test for one ALUT entry.
//   i_entry          : entry word as read from the RAM
//   i_t_latched      : current time captured at sweep start
//   i_thresh_latched : maximum allowed age captured at sweep start
//   o_expired        : entry is valid and older than the threshold
// Age is computed modulo 2**TW so a timestamp taken before the time counter
// wrapped still yields the correct (small) age.
// -----------------------------------------------------------------------------
module alut_age_cmp14
    import alut_pkg14::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic [DW-1:0] i_entry,
    input  logic [TW-1:0] i_t_latched,
    input  logic [TW-1:0] i_thresh_latched,
    output logic          o_expired
);
    logic [TW-1:0] w_age;
    logic          w_unused_fields;

    assign w_age     = i_t_latched - i_entry[TS_LSB +: TW];
    assign o_expired = i_entry[VALID_BIT] && (w_age > i_thresh_latched);

    // Port and MAC play no part in aging.
    assign w_unused_fields = &{1'b0, i_entry[PORT_MSB:MAC_LSB]};
endmodule

// File: rtl/alut_age_sweep14.sv
// -----------------------------------------------------------------------------
// alut_age_sweep14: ALUT age sweeper on the age-checker RAM port.
//   pclk14 / p_rst14      : clock, synchronous active-high reset
//   start14               : one-cycle sweep request (ignored while busy)
//   curr_time14           : free-running time, captured at start
//   age_thresh14          : maximum allowed age, captured at start
//   mem_if (master)       : age-port address/write/data, registered read
//                           data, snooped address-checker write port
//   busy14                : sweep in progress
//   done14                : one-cycle sweep-complete pulse
//   aged_cnt14            : entries invalidated in the last sweep
// Each entry is read, tested, and (if expired) overwritten with zero. A write
// from the address checker to the entry under test means it was relearned,
// so the entry is skipped.
// -----------------------------------------------------------------------------
module alut_age_sweep14
    import alut_pkg14::*;
#(
    parameter int DW = DW_DEF,
    parameter int DD = DD_DEF,
    parameter int AW = AW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                     pclk14,
    input  logic                     p_rst14,
    input  logic                     start14,
    input  logic [TW-1:0]            curr_time14,
    input  logic [TW-1:0]            age_thresh14,
    alut_age_sweep14_if.master       mem_if,
    output logic                     busy14,
    output logic                     done14,
    output logic [AW:0]              aged_cnt14
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DD - 1);

    sweep_state_t  r_state;
    sweep_state_t  w_next_state;
    logic [AW-1:0] r_addr;
    logic [TW-1:0] r_t_latched;
    logic [TW-1:0] r_thresh_latched;
    logic          r_conflict;
    logic [AW:0]   r_aged_cnt;

    logic          w_hit;
    logic          w_last;
    logic          w_expired;
    logic [AW-1:0] w_addr;
    logic          w_write;
    logic          w_busy;
    logic          w_done;

    alut_age_cmp14 #(.DW(DW), .TW(TW)) u_cmp (
        .i_entry          (mem_if.mem_read_data_age14),
        .i_t_latched      (r_t_latched),
        .i_thresh_latched (r_thresh_latched),
        .o_expired        (w_expired)
    );

    // Address checker writing the entry currently being aged.
    assign w_hit  = mem_if.mem_write_add14 && (mem_if.mem_addr_add14 == r_addr);
    assign w_last = (r_addr == LAST_ADDR);

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
    // branch rather than in the sensitivity list.
    always_ff @(posedge pclk14) begin
        if (p_rst14) begin
            r_state          <= ST_IDLE;
            r_addr           <= '0;
            r_t_latched      <= '0;
            r_thresh_latched <= '0;
            r_conflict       <= 1'b0;
            r_aged_cnt       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start14) begin
                        r_t_latched      <= curr_time14;
                        r_thresh_latched <= age_thresh14;
                        r_addr           <= '0;
                        r_aged_cnt       <= '0;
                    end
                end
                ST_READ:  r_conflict <= w_hit;
                ST_CHECK: if (w_hit) r_conflict <= 1'b1;
                ST_WRITE: if (!w_hit) r_aged_cnt <= r_aged_cnt + (AW+1)'(1);
                ST_NEXT:  if (!w_last) r_addr <= r_addr + AW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_addr       = r_addr;
        w_write      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_addr = '0;
                w_busy = 1'b0;
                if (start14) w_next_state = ST_READ;
            end
            ST_READ: w_next_state = ST_CHECK;
            ST_CHECK: begin
                // A same-cycle hit counts as a conflict immediately.
                if (w_expired && !r_conflict && !w_hit) w_next_state = ST_WRITE;
                else                                    w_next_state = ST_NEXT;
            end
            ST_WRITE: begin
                w_write      = !w_hit;
                w_next_state = ST_NEXT;
            end
            ST_NEXT: begin
                if (w_last) begin
                    w_done       = 1'b1;
                    w_busy       = 1'b0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            default: begin
                w_addr       = '0;
                w_busy       = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign mem_if.mem_addr_age14       = w_addr;
    assign mem_if.mem_write_age14      = w_write;
    assign mem_if.mem_write_data_age14 = '0;  // expired entries become invalid
    assign busy14                      = w_busy;
    assign done14                      = w_done;
    assign aged_cnt14                  = r_aged_cnt;
endmodule
